uart_csr_bank: RTL
==================

// Module: uart_csr_bank
// PURPOSE
//  Multi-channel UART configuration/status register bank; replaces per-channel single config regs.
//  Holds baud divisor, line control (data bits, parity, stop bits), interrupt enable and sticky status
//  for NUM_CH UART channels. Config writes land in shadow regs, applied atomically on COMMIT when channel idle.
//  Sits between host register bus and the UART TX/RX channel cores; drives per-channel config and irq.
// PARAMETERS
//  NUM_CH    4            number of UART channels (1..16)
//  CLK_HZ    50_000_000   system clock frequency, Hz
//  DEF_BAUD  115200       reset baud; reset divisor = CLK_HZ/(16*DEF_BAUD), truncated (27 at defaults)
//  ADDR_W    derived      $clog2(NUM_CH)+3 (localparam; min 4): addr[ADDR_W-1:3]=channel, addr[2:0]=reg
// PORTS
//  clk           in   1            system clock
//  rst_n         in   1            asynchronous, active-low reset
//  wr_en         in   1            register write strobe, single cycle
//  rd_en         in   1            register read strobe, single cycle
//  addr          in   ADDR_W       {channel, reg offset}
//  wr_data       in   32           write data
//  rd_data       out  32           read data, registered
//  rd_valid      out  1            high one cycle after rd_en
//  ch_busy       in   NUM_CH       channel mid-frame; blocks commit
//  ev_parity     in   NUM_CH       parity-error event pulse
//  ev_frame      in   NUM_CH       framing-error event pulse
//  ev_overrun    in   NUM_CH       RX overrun event pulse
//  cfg_baud_div  out  16*NUM_CH    active divisor, ch0 in [15:0]
//  cfg_lcr       out  6*NUM_CH     active {stop[1:0], parity_odd, parity_en, dbits[1:0]}, ch0 in [5:0]
//  irq           out  NUM_CH       per-channel interrupt, registered
// BEHAVIOUR
//  Reg map per channel: 0 BAUD_DIV[15:0] RW(shadow); 1 LCR[5:0] RW(shadow); 2 IER[2:0] RW;
//   3 STATUS RO/W1C {commit_pending[3], overrun[2], frame[1], parity[0]}; 4 CTRL bit0 COMMIT (WO, reads 0);
//   5 ACTIVE RO {lcr[21:16], baud_div[15:0]}; 6 LOCK (optional); 7 reads 0.
//  Reset: shadow and active BAUD_DIV = reset divisor; LCR = 6'b01_0_0_11 (1 stop, no parity, 8 bits);
//   IER=0, STATUS=0, rd_data=0, rd_valid=0, irq=0.
//  Read: rd_data/rd_valid one cycle after rd_en; unmapped fields read 0. Reads have no side effects.
//  Write: takes effect on the clk edge with wr_en; unused upper bits ignored.
//  Channel index >= NUM_CH: writes ignored, reads return 0 with rd_valid.
//  Commit: writing CTRL.COMMIT=1 sets commit_pending. Each cycle with pending and ch_busy=0: active <= shadow,
//   pending cleared (same edge). Commit while busy waits; pending visible in STATUS[3]; re-commit while pending no-op.
//  Shadow write while pending: new shadow value is what gets applied.
//  Status: ev_* sets sticky bit. W1C clears bit; event and W1C same cycle -> bit stays set (set wins).
//  irq[ch] <= |(STATUS[2:0] & IER[2:0]); 1-cycle latency from status change.
//  BAUD_DIV write of 0 stored as 1 (divisor never 0).
//  Simultaneous wr_en and rd_en same address: read returns pre-write value.
//  Reset asserted mid-operation: all state, including pending commit, returns to reset values immediately.
// CONFIGURATION
//  UART_CSR_LOCK_EN defined: offset 6 LOCK[0] RW per channel, reset 0. While LOCK=1, writes to BAUD_DIV, LCR
//   and COMMIT ignored; LOCK cleared only by writing 32'h0000_5A00 to offset 6; any write with bit0=1 sets it.
//  UART_CSR_LOCK_EN undefined: offset 6 reads 0, writes ignored; no lock logic synthesised.
// STRUCTURE
//  Package uart_csr_pkg: reg offset localparams, LCR field positions, LCR reset value, LOCK key, STATUS bits.
//  Sub-module uart_csr_chan: one channel's shadow/active regs, status, commit FSM (IDLE/PENDING), irq;
//   generated NUM_CH times. Top does address decode, read mux, rd_data/rd_valid registering.
// TESTING
//  Reset, read ch0 offsets 0,1,5 -> 27, 0x13, 0x0013_001B; rd_valid one cycle after each rd_en.
//  Write ch2 BAUD_DIV=54, COMMIT with ch_busy[2]=1 for 10 cycles -> STATUS[3]=1, cfg unchanged; drop busy -> div 54 next edge.
//  Pulse ev_parity[1] with W1C of bit0 same cycle -> STATUS[0] stays 1; W1C alone next -> 0.
//  IER[3]=3'b100, pulse ev_overrun[3] -> irq[3]=1 one cycle later; W1C bit2 -> irq[3]=0.
//  NUM_CH=3: write/read channel 3 -> no state change, rd_data=0; BAUD_DIV write 0 -> reads 1.
//  LOCK_EN: set LOCK ch0, write BAUD_DIV=99 -> reads 27; write 0x5A00 to offset 6 -> write 99 accepted.

Source files
------------

// File: rtl/uart_csr_pkg.sv
// Shared definitions for the UART configuration/status register bank.
// Holds the per-channel register offsets, LCR field positions and reset
// value, STATUS bit positions, the LOCK release key and the commit FSM state
// type. Imported by uart_csr_chan and uart_csr_bank.
package uart_csr_pkg;

   // Per-channel register offsets (addr[2:0])
   localparam logic [2:0] OFF_BAUD   = 3'd0;
   localparam logic [2:0] OFF_LCR    = 3'd1;
   localparam logic [2:0] OFF_IER    = 3'd2;
   localparam logic [2:0] OFF_STATUS = 3'd3;
   localparam logic [2:0] OFF_CTRL   = 3'd4;
   localparam logic [2:0] OFF_ACTIVE = 3'd5;
   localparam logic [2:0] OFF_LOCK   = 3'd6;

   // LCR = {stop[1:0], parity_odd, parity_en, dbits[1:0]}
   localparam int unsigned LCR_DBITS_LSB = 0;
   localparam int unsigned LCR_PAR_EN    = 2;
   localparam int unsigned LCR_PAR_ODD   = 3;
   localparam int unsigned LCR_STOP_LSB  = 4;
   localparam logic [5:0]  LCR_RST       = 6'b01_0_0_11;  // 1 stop, no parity, 8 bits

   // STATUS bit positions
   localparam int unsigned ST_PARITY  = 0;
   localparam int unsigned ST_FRAME   = 1;
   localparam int unsigned ST_OVERRUN = 2;
   localparam int unsigned ST_PENDING = 3;

   // Only this exact word clears LOCK
   localparam logic [31:0] LOCK_KEY = 32'h0000_5A00;

   typedef enum logic [0:0] {StIdle, StPending} commit_state_e;

endpackage

// File: rtl/uart_csr_bank_if.sv
// Host register bus for uart_csr_bank.
// Ports/signals: wr_en, rd_en (single-cycle strobes), addr[ADDR_W-1:0]
// ({channel, reg offset}), wr_data[31:0]; rd_data[31:0] and rd_valid are
// returned by the bank one cycle after rd_en.
// Modports: master (host side), slave (register bank side).
interface uart_csr_bank_if #(
   parameter int unsigned ADDR_W = 5
) ();
   logic              wr_en;
   logic              rd_en;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wr_data;
   logic [31:0]       rd_data;
   logic              rd_valid;

   modport master (output wr_en, rd_en, addr, wr_data, input rd_data, rd_valid);
   modport slave  (input wr_en, rd_en, addr, wr_data, output rd_data, rd_valid);
endinterface

// File: rtl/uart_csr_chan.sv
// One UART channel's register set: shadow and active baud divisor / LCR,
// IER, sticky STATUS, commit FSM (idle/pending) and registered irq.
// Ports: clk, rst_n (async, active-low); wr_en (already decoded for this
// channel), offset[2:0], wr_data[31:0]; ch_busy blocks commit; ev_parity,
// ev_frame, ev_overrun event pulses; rd_word (combinational read word for
// offset); baud_div/lcr active config; irq.
// Optional feature: UART_CSR_LOCK_EN adds a per-channel LOCK register.
module uart_csr_chan
   import uart_csr_pkg::*;
#(
   parameter logic [15:0] RST_DIV = 16'd27
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [2:0]  offset,
   input  logic [31:0] wr_data,
   input  logic        ch_busy,
   input  logic        ev_parity,
   input  logic        ev_frame,
   input  logic        ev_overrun,
   output logic [31:0] rd_word,
   output logic [15:0] baud_div,
   output logic [5:0]  lcr,
   output logic        irq
);

   commit_state_e state_q;
   logic [15:0]   shadow_div_q, shadow_div_d, div_q;
   logic [5:0]    shadow_lcr_q, shadow_lcr_d, lcr_q;
   logic [2:0]    ier_q, ier_d;
   logic [2:0]    status_q, status_d;
   logic [2:0]    w1c;
   logic          irq_q;
   logic          commit_req;
   logic          cfg_wr_ok;

`ifdef UART_CSR_LOCK_EN
   logic lock_q, lock_d;

   assign cfg_wr_ok = ~lock_q;

   always_comb begin
      lock_d = lock_q;
      if (wr_en && offset == OFF_LOCK) begin
         if (wr_data == LOCK_KEY)  lock_d = 1'b0;
         else if (wr_data[0])      lock_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lock_q <= 1'b0;
      else        lock_q <= lock_d;
   end
`else
   logic unused_wr_hi;

   assign cfg_wr_ok    = 1'b1;
   assign unused_wr_hi = ^wr_data[31:16];
`endif

   always_comb begin
      shadow_div_d = shadow_div_q;
      shadow_lcr_d = shadow_lcr_q;
      ier_d        = ier_q;
      w1c          = 3'b000;
      commit_req   = 1'b0;
      if (wr_en) begin
         case (offset)
            OFF_BAUD:   if (cfg_wr_ok) shadow_div_d = (wr_data[15:0] == 16'd0) ? 16'd1
                                                                               : wr_data[15:0];
            OFF_LCR:    if (cfg_wr_ok) shadow_lcr_d = wr_data[5:0];
            OFF_IER:    ier_d = wr_data[2:0];
            OFF_STATUS: w1c = wr_data[2:0];
            OFF_CTRL:   commit_req = wr_data[0] & cfg_wr_ok;
            default:    ;
         endcase
      end
      // A new event in the same cycle as its W1C keeps the bit set
      status_d = (status_q & ~w1c) | {ev_overrun, ev_frame, ev_parity};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_div_q <= RST_DIV;
         shadow_lcr_q <= LCR_RST;
         ier_q        <= 3'b000;
         status_q     <= 3'b000;
         irq_q        <= 1'b0;
      end else begin
         shadow_div_q <= shadow_div_d;
         shadow_lcr_q <= shadow_lcr_d;
         ier_q        <= ier_d;
         status_q     <= status_d;
         irq_q        <= |(status_q & ier_q);
      end
   end

   // Commit FSM; applies the next-shadow value so a same-cycle shadow write wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         div_q   <= RST_DIV;
         lcr_q   <= LCR_RST;
      end else begin
         case (state_q)
            StIdle: if (commit_req) state_q <= StPending;
            StPending: begin
               if (!ch_busy) begin
                  div_q   <= shadow_div_d;
                  lcr_q   <= shadow_lcr_d;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      rd_word = 32'd0;
      case (offset)
         OFF_BAUD:   rd_word = {16'd0, shadow_div_q};
         OFF_LCR:    rd_word = {26'd0, shadow_lcr_q};
         OFF_IER:    rd_word = {29'd0, ier_q};
         OFF_STATUS: rd_word = {28'd0, (state_q == StPending), status_q};
         OFF_ACTIVE: rd_word = {10'd0, lcr_q, div_q};
`ifdef UART_CSR_LOCK_EN
         OFF_LOCK:   rd_word = {31'd0, lock_q};
`endif
         default:    rd_word = 32'd0;
      endcase
   end

   assign baud_div = div_q;
   assign lcr      = lcr_q;
   assign irq      = irq_q;

endmodule

// File: rtl/uart_csr_bank.sv
// Multi-channel UART configuration/status register bank (top).
// Decodes {channel, offset} from the host bus, fans writes out to NUM_CH
// uart_csr_chan instances, muxes and registers read data.
// Ports: clk, rst_n (async, active-low); bus (uart_csr_bank_if.slave:
// wr_en, rd_en, addr, wr_data, rd_data, rd_valid); ch_busy, ev_parity,
// ev_frame, ev_overrun [NUM_CH]; cfg_baud_div [16*NUM_CH]; cfg_lcr [6*NUM_CH];
// irq [NUM_CH]. Channel 0 occupies the least-significant slice of each bus.
// Optional feature: define UART_CSR_LOCK_EN for per-channel LOCK at offset 6.
module uart_csr_bank
   import uart_csr_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned DEF_BAUD = 115200
) (
   input  logic                 clk,
   input  logic                 rst_n,
   uart_csr_bank_if.slave       bus,
   input  logic [NUM_CH-1:0]    ch_busy,
   input  logic [NUM_CH-1:0]    ev_parity,
   input  logic [NUM_CH-1:0]    ev_frame,
   input  logic [NUM_CH-1:0]    ev_overrun,
   output logic [16*NUM_CH-1:0] cfg_baud_div,
   output logic [6*NUM_CH-1:0]  cfg_lcr,
   output logic [NUM_CH-1:0]    irq
);

   // At least one channel-select bit, so ADDR_W is never below 4
   localparam int unsigned CH_W    = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1;
   localparam int unsigned ADDR_W  = CH_W + 3;
   localparam int unsigned DIV_RAW = CLK_HZ / (16 * DEF_BAUD);
   localparam logic [15:0] RST_DIV = (DIV_RAW == 0)     ? 16'd1 :
                                     (DIV_RAW > 65535)  ? 16'hFFFF : 16'(DIV_RAW);

   logic [CH_W-1:0]   ch_idx;
   logic [2:0]        offset;
   logic [NUM_CH-1:0] ch_wr;
   logic [31:0]       ch_rdata [NUM_CH];
   logic [31:0]       rd_mux;
   logic [31:0]       rd_data_q;
   logic              rd_valid_q;

   assign ch_idx = bus.addr[ADDR_W-1:3];
   assign offset = bus.addr[2:0];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_wr[i] = bus.wr_en && (ch_idx == CH_W'(i));

      uart_csr_chan #(
         .RST_DIV (RST_DIV)
      ) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .wr_en      (ch_wr[i]),
         .offset     (offset),
         .wr_data    (bus.wr_data),
         .ch_busy    (ch_busy[i]),
         .ev_parity  (ev_parity[i]),
         .ev_frame   (ev_frame[i]),
         .ev_overrun (ev_overrun[i]),
         .rd_word    (ch_rdata[i]),
         .baud_div   (cfg_baud_div[16*i +: 16]),
         .lcr        (cfg_lcr[6*i +: 6]),
         .irq        (irq[i])
      );
   end

   // Channel indices past NUM_CH match nothing and read 0
   always_comb begin
      rd_mux = 32'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_idx == CH_W'(i)) rd_mux = ch_rdata[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= 32'd0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) rd_data_q <= rd_mux;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;

endmodule
